// File: rtl/crt_frame_dump_pkg.sv
// Shared constants and state type for the CRT frame dump block.
package crt_pkg;

  localparam int unsigned COLS_DEF     = 40;
  localparam int unsigned ROWS_DEF     = 6;
  localparam int unsigned FRAME_PIXELS = COLS_DEF * ROWS_DEF;

  localparam logic [7:0] ASCII_LIT  = 8'h23;
  localparam logic [7:0] ASCII_DARK = 8'h2E;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SEND    = 2'd1,
    DONE    = 2'd2
  } crt_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter; ready re-asserts on the last stop-bit cycle for gapless streaming.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [BW-1:0] baud;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));
  assign ready   = !active || (bit_end && (bit_idx == 4'd9));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (start && ready) begin
      // Start bit goes out immediately; remaining data+stop bits sit in the shifter.
      active  <= 1'b1;
      tx      <= 1'b0;
      shreg   <= {1'b1, data};
      baud    <= '0;
      bit_idx <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud <= baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/crt_frame_dump.sv
// Captures one CRT frame of lit/dark pixels and dumps it as ASCII art over an 8N1 UART.
module crt_frame_dump
  import crt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned ROWS         = ROWS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_valid,
  input  logic pix_in,
  output logic tx,
  output logic busy,
  output logic done
);

  localparam int unsigned NPIX = COLS * ROWS;
  localparam int unsigned IW   = $clog2(NPIX);
  localparam int unsigned CW   = $clog2(COLS + 1);
  localparam int unsigned RW   = $clog2(ROWS + 1);
  localparam logic [IW-1:0] LAST_PIX = IW'(NPIX - 1);

  crt_state_t    state, state_next;
  logic [NPIX-1:0] frame;
  logic [IW-1:0] cap_idx;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          start;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          is_lf;

  assign busy  = (state == SEND);
  assign done  = (state == DONE);
  assign is_lf = (col == CW'(COLS));

  always_comb begin
    tx_data = ASCII_LF;
    if (!is_lf) tx_data = frame[rd_idx] ? ASCII_LIT : ASCII_DARK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CAPTURE;
    else      state <= state_next;
  end

  // Byte 0 is issued on the same edge that stores the last pixel, so the
  // first start bit lines up with the cycle that busy rises.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      CAPTURE: begin
        if (pix_valid && (cap_idx == LAST_PIX)) begin
          state_next = SEND;
          start      = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (row == RW'(ROWS)) state_next = DONE;
          else                  start      = 1'b1;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_idx <= '0;
      rd_idx  <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      if ((state == CAPTURE) && pix_valid && (cap_idx != LAST_PIX))
        cap_idx <= cap_idx + 1'b1;
      if (start) begin
        if (is_lf) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col    <= col + 1'b1;
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && (state == CAPTURE) && pix_valid) frame[cap_idx] <= pix_in;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (tx_data),
    .tx   (tx),
    .ready(tx_ready)
  );

endmodule

// File: tb/tb_crt_frame_dump.sv
// Directed/randomised bench for crt_frame_dump with a frame-level reference model and UART decoder.
module tb_crt_frame_dump;

  localparam int unsigned CPB    = 4;
  localparam int unsigned COLS   = 40;
  localparam int unsigned ROWS   = 6;
  localparam int unsigned NPIX   = COLS * ROWS;
  localparam int unsigned NBYTES = ROWS * (COLS + 1);

  logic clk = 1'b0;
  logic rst, pix_valid, pix_in;
  logic tx, busy, done;

  int unsigned n_cmp   = 0;
  int unsigned n_err   = 0;
  int unsigned cyc     = 0;
  int unsigned cap_cyc = 0;
  bit          exp_pix [NPIX];

  crt_frame_dump #(
    .CLKS_PER_BIT(CPB),
    .COLS        (COLS),
    .ROWS        (ROWS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_valid(pix_valid),
    .pix_in   (pix_in),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int unsigned b);
    int unsigned r = b / (COLS + 1);
    int unsigned c = b % (COLS + 1);
    if (c == COLS) return 8'h0A;
    return exp_pix[r * COLS + c] ? 8'h23 : 8'h2E;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 lit, 1 index parity, 2 lit only past the frame, 3 random, 4 dark
  // gap:  0 none, 1 every third cycle idle, 2 random idle cycles
  task automatic feed(input int unsigned n, input int unsigned mode, input int unsigned gap);
    int unsigned k = 0;
    int unsigned s = 0;
    logic v, p;
    while (k < n) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = ((s % 3) != 2);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s++;
      if (v) begin
        case (mode)
          0:       p = 1'b1;
          1:       p = k[0];
          2:       p = (k >= NPIX);
          3:       p = 1'($urandom_range(0, 1));
          default: p = 1'b0;
        endcase
        if (k < NPIX) exp_pix[k] = p;
        if (k == NPIX - 1) cap_cyc = cyc + 1;
        k++;
      end else begin
        p = 1'($urandom_range(0, 1));
      end
      pix_valid = v;
      pix_in    = p;
      step();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    int unsigned n = 0;
    while (!busy && n < 3000) begin
      step();
      n++;
    end
    ok = busy;
    if (!ok) check("busy_rise_timeout", 64'd0, 64'd1);
  endtask

  task automatic rx_frame();
    bit          ok;
    int unsigned t0;
    int unsigned unstable = 0;
    int unsigned idx;
    logic [9:0]  fr;
    logic        first;
    logic [40:0] seq_obs;
    logic [40:0] seq_exp;
    logic [7:0]  b0;
    int unsigned lvl;
    seq_obs = '0;
    first   = 1'b0;
    fr      = '0;
    wait_busy(ok);
    if (!ok) return;
    t0 = cyc;
    check("start_latency", 64'(t0), 64'(cap_cyc));
    for (int unsigned b = 0; b < NBYTES; b++) begin
      for (int unsigned i = 0; i < 10; i++) begin
        for (int unsigned j = 0; j < CPB; j++) begin
          idx = (b * 10 + i) * CPB + j;
          if (idx < 41) seq_obs[idx] = tx;
          if (j == 0) first = tx;
          else if (tx !== first) unstable++;
          if (j == CPB / 2) fr[i] = tx;
          if (idx == NBYTES * 10 * CPB - 1) check("busy_last_stop", 64'(busy), 64'd1);
          step();
        end
      end
      check($sformatf("byte%0d", b), 64'(fr), 64'({1'b1, exp_byte(b), 1'b0}));
    end
    b0 = exp_byte(0);
    for (int unsigned k = 0; k < 41; k++) begin
      lvl = k / CPB;
      if (lvl == 0)      seq_exp[k] = 1'b0;
      else if (lvl <= 8) seq_exp[k] = b0[lvl-1];
      else if (lvl == 9) seq_exp[k] = 1'b1;
      else               seq_exp[k] = 1'b0;
    end
    check("first_byte_bits", 64'(seq_obs), 64'(seq_exp));
    check("bit_hold", 64'(unstable), 64'd0);
    check("send_length", 64'(cyc - t0), 64'(NBYTES * 10 * CPB));
    check("done_rise", 64'(done), 64'd1);
    check("busy_fall", 64'(busy), 64'd0);
    check("tx_idle_after", 64'(tx), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    bit          ok;
    int unsigned bad;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // All-lit frame
    fork
      feed(NPIX, 0, 0);
      rx_frame();
    join

    // Pixels in DONE are ignored and done stays set
    bad = 0;
    pix_valid = 1'b1;
    pix_in    = 1'b1;
    for (int unsigned n = 0; n < 50; n++) begin
      step();
      if (tx !== 1'b1 || done !== 1'b1 || busy !== 1'b0) bad++;
    end
    pix_valid = 1'b0;
    check("done_sticky", 64'(bad), 64'd0);

    do_reset();
    check("reset_clears_done", 64'(done), 64'd0);

    // Alternating pattern with every third cycle idle
    fork
      feed(NPIX, 1, 1);
      rx_frame();
    join

    // Overrun: extra lit pixels after a dark frame
    do_reset();
    fork
      feed(300, 2, 0);
      rx_frame();
    join

    // Async reset during byte 17, bit 5
    do_reset();
    fork
      feed(NPIX, 3, 0);
      begin
        wait_busy(ok);
        if (ok) begin
          repeat (17 * 10 * CPB + 5 * CPB + 1) step();
          rst = 1'b0;
          #2;
          check("midsend_tx", 64'(tx), 64'd1);
          check("midsend_busy", 64'(busy), 64'd0);
          check("midsend_done", 64'(done), 64'd0);
        end
      end
    join
    repeat (2) step();
    rst = 1'b1;
    step();
    check("post_reset_idle", 64'(busy), 64'd0);
    fork
      feed(NPIX, 4, 0);
      rx_frame();
    join

    // Async reset mid-capture at pixel 100, then a random gappy frame
    do_reset();
    feed(100, 3, 2);
    check("midcap_not_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    fork
      feed(NPIX, 3, 2);
      rx_frame();
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
